spi_reg_peripheral: RTL and testbench

//  SPI Mode-0 target that receives 16-bit write frames from an off-chip controller and

---
 rtl/spi_reg_pkg.sv | 21 ++
 rtl/sync_ff.sv | 28 ++
 rtl/spi_reg_peripheral.sv | 144 ++++++++++++++
 tb/tb_spi_reg_peripheral.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register peripheral.
//   FrameBits     : bits per SPI frame ([15]=R/W, [14:8]=addr, [7:0]=data)
//   Addr*         : register addresses decoded by spi_reg_peripheral
//   spi_state_e   : receive FSM state encoding
package spi_reg_pkg;

  localparam int unsigned FrameBits = 16;

  localparam logic [6:0] AddrEnOutLo = 7'h00;
  localparam logic [6:0] AddrEnOutHi = 7'h01;
  localparam logic [6:0] AddrEnPwmLo = 7'h02;
  localparam logic [6:0] AddrEnPwmHi = 7'h03;
  localparam logic [6:0] AddrDuty    = 7'h04;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRecv    = 2'd1,
    StOverrun = 2'd2
  } spi_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous input bit.
//   clk_i  : destination clock
//   rst_ni : synchronous active-low reset, loads ResetVal into every stage
//   d_i    : asynchronous input
//   q_o    : synchronized output (last stage)
module sync_ff #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {Stages{ResetVal}};
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI Mode-0 write-only target holding the five PWM control registers.
//   clk, rst_n        : system clock, synchronous active-low reset
//   sclk, ncs, copi   : asynchronous SPI pins (sclk idles low, ncs active-low)
//   en_reg_*, pwm_duty_cycle : register file contents, addresses 0x00..0x04
//   frame_done        : 1-cycle pulse when a valid write commits
//   frame_err         : 1-cycle pulse when a frame is discarded
// NumRegs must be at least 5 since all five outputs are always driven.
module spi_reg_peripheral #(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned NumRegs    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       ncs,
  input  logic       copi,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_done,
  output logic       frame_err
);

  import spi_reg_pkg::*;

  localparam logic [6:0] NumRegsAddr = 7'(NumRegs);
  localparam logic [4:0] FullCount   = 5'(FrameBits);

  logic sclk_s, ncs_s, copi_s;
  logic sclk_hist_q, ncs_hist_q;

  sync_ff #(.Stages(SyncStages), .ResetVal(1'b0)) u_sync_sclk (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (sclk),
    .q_o    (sclk_s)
  );

  sync_ff #(.Stages(SyncStages), .ResetVal(1'b1)) u_sync_ncs (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (ncs),
    .q_o    (ncs_s)
  );

  sync_ff #(.Stages(SyncStages), .ResetVal(1'b0)) u_sync_copi (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (copi),
    .q_o    (copi_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_hist_q <= 1'b0;
      ncs_hist_q  <= 1'b1;
    end else begin
      sclk_hist_q <= sclk_s;
      ncs_hist_q  <= ncs_s;
    end
  end

  logic sclk_rise, ncs_fall, ncs_rise;
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign ncs_fall  = ~ncs_s & ncs_hist_q;
  assign ncs_rise  = ncs_s & ~ncs_hist_q;

  spi_state_e             state_q;
  logic [4:0]             count_q;
  logic [FrameBits-1:0]   shift_q;
  logic [7:0]             regs_q [NumRegs];
  logic                   frame_done_q, frame_err_q;

  logic [6:0] frame_addr;
  logic       frame_ok;
  assign frame_addr = shift_q[14:8];
  assign frame_ok   = (count_q == FullCount) && shift_q[15] && (frame_addr < NumRegsAddr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      count_q      <= '0;
      shift_q      <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      for (int unsigned i = 0; i < NumRegs; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ncs_fall) begin
            state_q <= StRecv;
            count_q <= '0;
            shift_q <= '0;
          end
        end
        StRecv: begin
          // ncs rise takes priority so a coincident sclk edge is not counted
          if (ncs_rise) begin
            state_q <= StIdle;
            if (frame_ok) begin
              for (int unsigned i = 0; i < NumRegs; i++) begin
                if (frame_addr == 7'(i)) begin
                  regs_q[i] <= shift_q[7:0];
                end
              end
              frame_done_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else if (sclk_rise) begin
            if (count_q == FullCount) begin
              state_q <= StOverrun;
            end else begin
              shift_q <= {shift_q[FrameBits-2:0], copi_s};
              count_q <= count_q + 5'd1;
            end
          end
        end
        StOverrun: begin
          if (ncs_rise) begin
            state_q     <= StIdle;
            frame_err_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign frame_done      = frame_done_q;
  assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
module tb_spi_reg_peripheral;

  localparam int T = 10;

  logic       clk, rst_n, sclk, ncs, copi;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       frame_done, frame_err;

  spi_reg_peripheral dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclk            (sclk),
    .ncs             (ncs),
    .copi            (copi),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .frame_done      (frame_done),
    .frame_err       (frame_err)
  );

  initial clk = 1'b0;
  always #(T / 2) clk = ~clk;

  typedef struct {
    bit              is_done;
    logic [4:0][7:0] regs;
    time             t_rise;
    string           name;
  } exp_t;

  exp_t            sb_q[$];
  exp_t            mon_e;
  logic [4:0][7:0] model_regs;
  logic [4:0][7:0] dut_regs;
  int              n_vec = 0;
  int              n_err = 0;

  assign dut_regs = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                     en_reg_out_15_8, en_reg_out_7_0};

  // Monitor: every pulse pops one expectation and checks kind, latency and all regs.
  always @(negedge clk) begin
    if (frame_done || frame_err) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: got done=%0b err=%0b, required no pulse",
                 frame_done, frame_err);
      end else begin
        mon_e = sb_q.pop_front();
        if ({frame_done, frame_err} != {mon_e.is_done, ~mon_e.is_done}) begin
          n_err++;
          $display("FAIL %s pulse: got done=%0b err=%0b, required done=%0b err=%0b",
                   mon_e.name, frame_done, frame_err, mon_e.is_done, ~mon_e.is_done);
        end
        n_vec++;
        if (dut_regs != mon_e.regs) begin
          n_err++;
          $display("FAIL %s regs: got %h, required %h", mon_e.name, dut_regs, mon_e.regs);
        end
        n_vec++;
        if (($time - mon_e.t_rise) > 4 * T) begin
          n_err++;
          $display("FAIL %s latency: got %0t after ncs rise, required <= %0d",
                   mon_e.name, $time - mon_e.t_rise, 4 * T);
        end
      end
    end
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int nbits, input int ph);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = bits[i];
      #(ph * T) sclk = 1'b1;
      #(ph * T) sclk = 1'b0;
    end
  endtask

  task automatic push_exp(input bit is_done, input string name);
    exp_t e;
    e.is_done = is_done;
    e.regs    = model_regs;
    e.t_rise  = $time;
    e.name    = name;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout: got %0d pending, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic issue_frame(input logic [31:0] bits, input int nbits, input int ph,
                             input string name);
    int  addr;
    bit  ok;
    ncs = 1'b0;
    #(ph * T);
    shift_bits(bits, nbits, ph);
    #(ph * T);
    addr = int'(bits[14:8]);
    ok   = (nbits == 16) && bits[15] && (addr < 5);
    if (ok) model_regs[addr] = bits[7:0];
    push_exp(ok, name);
    ncs = 1'b1;
    #(2 * ph * T);
    wait_drain(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fr;
    rst_n = 1'b0; sclk = 1'b0; ncs = 1'b1; copi = 1'b0;
    model_regs = '0;

    // 1: reset with raw sclk toggling
    for (int i = 0; i < 8; i++) #7 sclk = ~sclk;
    sclk = 1'b0;
    @(negedge clk);
    check8("reset_reg0", en_reg_out_7_0, 8'h00);
    check8("reset_reg1", en_reg_out_15_8, 8'h00);
    check8("reset_reg2", en_reg_pwm_7_0, 8'h00);
    check8("reset_reg3", en_reg_pwm_15_8, 8'h00);
    check8("reset_reg4", pwm_duty_cycle, 8'h00);
    check8("reset_pulses", {6'b0, frame_done, frame_err}, 8'h00);
    #1 rst_n = 1'b1;
    // sclk edges with ncs high must be ignored
    for (int i = 0; i < 6; i++) #(4 * T) sclk = ~sclk;
    #(8 * T);

    // 2: duty cycle write
    issue_frame(32'h8455, 16, 4, "write_duty");

    // 3: remaining registers, then a bad address
    issue_frame(32'h80A1, 16, 4, "write_r0");
    issue_frame(32'h81B2, 16, 4, "write_r1");
    issue_frame(32'h82C3, 16, 4, "write_r2");
    issue_frame(32'h83D4, 16, 4, "write_r3");
    issue_frame(32'h8577, 16, 4, "bad_addr");

    // 4: read, short, long, then valid
    issue_frame(32'h0012, 16, 4, "read_frame");
    issue_frame(32'h40AB, 15, 4, "short_frame");
    issue_frame(32'h1_0155, 17, 4, "long_frame");
    issue_frame(32'h8001, 16, 4, "write_r0_01");

    // 5: reset mid-frame; the frame resumed after release is short
    ncs = 1'b0;
    #(4 * T);
    shift_bits(32'h83, 8, 4);
    #(2 * T);
    @(posedge clk); #1 rst_n = 1'b0;
    model_regs = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    shift_bits(32'hFF, 8, 4);
    #(4 * T);
    push_exp(1'b0, "reset_midframe");
    ncs = 1'b1;
    #(8 * T);
    wait_drain("reset_midframe");
    check8("midframe_reg3", en_reg_pwm_15_8, 8'h00);
    issue_frame(32'h83FF, 16, 4, "post_reset_write");

    // 6: minimum timing, random clk/sclk phase
    for (int n = 0; n < 200; n++) begin
      #($urandom_range(0, T - 1));
      fr = {16'h0, 1'b1, 7'($urandom_range(0, 4)), 8'($urandom)};
      issue_frame(fr, 16, 3, "stress");
    end

    @(negedge clk);
    check8("final_reg0", en_reg_out_7_0, model_regs[0]);
    check8("final_reg1", en_reg_out_15_8, model_regs[1]);
    check8("final_reg2", en_reg_pwm_7_0, model_regs[2]);
    check8("final_reg3", en_reg_pwm_15_8, model_regs[3]);
    check8("final_reg4", pwm_duty_cycle, model_regs[4]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
